// File: rtl/carpma_birimi_hatli.sv
// rtl/carpma_birimi_hatli.sv - pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU)
// Stage 1 holds four half-width partial products; later stages add, select and delay.
module carpma_birimi_hatli #(
  parameter int VERI_GENISLIGI = 32,
  parameter int ASAMA_SAYISI   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      durdur_i,
  input  logic                      temizle_i,
  input  logic                      gecerli_i,
  input  logic [1:0]                kontrol_i,
  input  logic [VERI_GENISLIGI-1:0] deger1_i,
  input  logic [VERI_GENISLIGI-1:0] deger2_i,
  output logic [VERI_GENISLIGI-1:0] sonuc_o,
  output logic                      gecerli_o,
  output logic                      mesgul_o
);
  localparam int W  = VERI_GENISLIGI;
  localparam int H  = W / 2;
  localparam int NR = (ASAMA_SAYISI == 1) ? 1 : ASAMA_SAYISI - 1;

  localparam logic [1:0] CARPMA_MUL    = 2'd0;
  localparam logic [1:0] CARPMA_MULH   = 2'd1;
  localparam logic [1:0] CARPMA_MULHSU = 2'd2;
  localparam logic [1:0] CARPMA_MULHU  = 2'd3;

  logic                isaret1, isaret2;
  logic [W:0]          a_ext, b_ext;
  logic signed [W+1:0] a_hi_x, b_hi_x, a_lo_x, b_lo_x;
  logic signed [W+1:0] pp_hh_d, pp_hl_d, pp_lh_d;
  logic [W-1:0]        pp_ll_d;

  // Operands are widened by one bit so all four ops share one signed multiplier.
  assign isaret1 = ((kontrol_i == CARPMA_MULH) || (kontrol_i == CARPMA_MULHSU)) && deger1_i[W-1];
  assign isaret2 = (kontrol_i == CARPMA_MULH) && deger2_i[W-1];
  assign a_ext   = {isaret1, deger1_i};
  assign b_ext   = {isaret2, deger2_i};

  assign a_hi_x  = {{(H+1){a_ext[W]}}, a_ext[W:H]};
  assign b_hi_x  = {{(H+1){b_ext[W]}}, b_ext[W:H]};
  assign a_lo_x  = {{(H+2){1'b0}}, a_ext[H-1:0]};
  assign b_lo_x  = {{(H+2){1'b0}}, b_ext[H-1:0]};

  assign pp_hh_d = a_hi_x * b_hi_x;
  assign pp_hl_d = a_hi_x * b_lo_x;
  assign pp_lh_d = a_lo_x * b_hi_x;
  assign pp_ll_d = {{H{1'b0}}, a_ext[H-1:0]} * {{H{1'b0}}, b_ext[H-1:0]};

  function automatic logic [2*W-1:0] topla(input logic signed [W+1:0] hh,
                                           input logic signed [W+1:0] hl,
                                           input logic signed [W+1:0] lh,
                                           input logic [W-1:0]        ll);
    logic [2*W-1:0] s_hh, s_hl, s_lh, s_ll;
    s_hh = {{(W-2){hh[W+1]}}, hh};
    s_hl = {{(W-2){hl[W+1]}}, hl};
    s_lh = {{(W-2){lh[W+1]}}, lh};
    s_ll = {{W{1'b0}}, ll};
    return (s_hh << W) + ((s_hl + s_lh) << H) + s_ll;
  endfunction

  function automatic logic [W-1:0] sec(input logic [1:0] k, input logic [2*W-1:0] p);
    return (k == CARPMA_MUL) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  logic          zincir_vld_d;
  logic [W-1:0]  zincir_dat_d;
  logic          on_mesgul;

  generate
    if (ASAMA_SAYISI == 1) begin : g_tek
      assign zincir_vld_d = gecerli_i;
      assign zincir_dat_d = sec(kontrol_i, topla(pp_hh_d, pp_hl_d, pp_lh_d, pp_ll_d));
      assign on_mesgul    = 1'b0;
    end else begin : g_hatli
      logic signed [W+1:0] pp_hh_q, pp_hl_q, pp_lh_q;
      logic [W-1:0]        pp_ll_q;
      logic [1:0]          kontrol_q;
      logic                vld1_q;

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          vld1_q    <= 1'b0;
          kontrol_q <= 2'd0;
          pp_hh_q   <= '0;
          pp_hl_q   <= '0;
          pp_lh_q   <= '0;
          pp_ll_q   <= '0;
        end else if (temizle_i) begin
          vld1_q    <= 1'b0;
        end else if (!durdur_i) begin
          vld1_q    <= gecerli_i;
          kontrol_q <= kontrol_i;
          pp_hh_q   <= pp_hh_d;
          pp_hl_q   <= pp_hl_d;
          pp_lh_q   <= pp_lh_d;
          pp_ll_q   <= pp_ll_d;
        end
      end

      assign zincir_vld_d = vld1_q;
      assign zincir_dat_d = sec(kontrol_q, topla(pp_hh_q, pp_hl_q, pp_lh_q, pp_ll_q));
      assign on_mesgul    = vld1_q;
    end
  endgenerate

  // Result stage followed by pure delay stages; the last one drives the outputs.
  logic [NR-1:0] vld_q;
  logic [W-1:0]  dat_q [NR];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NR; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else if (temizle_i) begin
      vld_q <= '0;
    end else if (!durdur_i) begin
      vld_q[0] <= zincir_vld_d;
      dat_q[0] <= zincir_dat_d;
      for (int i = 1; i < NR; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign sonuc_o   = dat_q[NR-1];
  assign gecerli_o = vld_q[NR-1];
  assign mesgul_o  = (|vld_q) | on_mesgul;
endmodule

// File: tb/tb_carpma_birimi_hatli.sv
// tb/tb_carpma_birimi_hatli.sv - self-checking bench for carpma_birimi_hatli (W=32, 3 stages)
module tb_carpma_birimi_hatli;
  localparam int W = 32;
  localparam int S = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          durdur_i = 1'b0, temizle_i = 1'b0, gecerli_i = 1'b0;
  logic [1:0]    kontrol_i = 2'd0;
  logic [W-1:0]  deger1_i = '0, deger2_i = '0;
  logic [W-1:0]  sonuc_o;
  logic          gecerli_o, mesgul_o;

  int checks = 0;
  int errors = 0;

  carpma_birimi_hatli #(.VERI_GENISLIGI(W), .ASAMA_SAYISI(S)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .durdur_i(durdur_i), .temizle_i(temizle_i),
    .gecerli_i(gecerli_i), .kontrol_i(kontrol_i), .deger1_i(deger1_i), .deger2_i(deger2_i),
    .sonuc_o(sonuc_o), .gecerli_o(gecerli_o), .mesgul_o(mesgul_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tablo [17];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic g, input logic [1:0] k, input logic [W-1:0] a, input logic [W-1:0] b);
    gecerli_i = g;
    kontrol_i = k;
    deger1_i  = a;
    deger2_i  = b;
  endtask

  function automatic logic [W-1:0] ref_model(input logic [1:0] k, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [65:0] x, y, p;
    x = (k == 2'd1 || k == 2'd2) ? $signed({{34{a[W-1]}}, a}) : $signed({34'b0, a});
    y = (k == 2'd1)              ? $signed({{34{b[W-1]}}, b}) : $signed({34'b0, b});
    p = x * y;
    return (k == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  logic          mv [S];
  logic [W-1:0]  md [S];

  initial begin
    tablo[0]  = '{2'd0, 32'd121,        32'hFFFFFFBA, 32'hFFFFDEEA};
    tablo[1]  = '{2'd1, 32'h00110000,   32'hFFFFFFFF, 32'hFFFFFFFF};
    tablo[2]  = '{2'd2, 32'h00110000,   32'hFFFFFFFF, 32'h0010FFFF};
    tablo[3]  = '{2'd3, 32'h00110000,   32'hFFFFFFFF, 32'h0010FFFF};
    tablo[4]  = '{2'd0, 32'h00000000,   32'h12345678, 32'h00000000};
    tablo[5]  = '{2'd0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001};
    tablo[6]  = '{2'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000};
    tablo[7]  = '{2'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE};
    tablo[8]  = '{2'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF};
    tablo[9]  = '{2'd1, 32'h80000000,   32'h80000000, 32'h40000000};
    tablo[10] = '{2'd3, 32'h80000000,   32'h80000000, 32'h40000000};
    tablo[11] = '{2'd2, 32'h80000000,   32'h80000000, 32'hC0000000};
    tablo[12] = '{2'd0, 32'h0F000000,   32'h0F000000, 32'h00000000};
    tablo[13] = '{2'd1, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF};
    tablo[14] = '{2'd0, 32'h12345678,   32'h00000010, 32'h23456780};
    tablo[15] = '{2'd2, 32'h80000000,   32'hFFFFFFFF, 32'h80000000};
    tablo[16] = '{2'd1, 32'h00000002,   32'hFFFFFFFD, 32'hFFFFFFFF};

    #12;
    chk("reset_sonuc", sonuc_o, '0);
    chk("reset_gecerli", {31'b0, gecerli_o}, 0);
    chk("reset_mesgul", {31'b0, mesgul_o}, 0);
    rst_i = 1'b1;
    step();

    // Back-to-back table: result of vector i appears after the edge S-1 cycles later.
    for (int i = 0; i < 17 + S - 1; i++) begin
      if (i < 17) drive(1'b1, tablo[i].ctl, tablo[i].a, tablo[i].b);
      else        drive(1'b0, 2'd0, '0, '0);
      step();
      if (i < S - 1) begin
        chk($sformatf("latency_gecerli_%0d", i), {31'b0, gecerli_o}, 0);
      end else begin
        chk($sformatf("vec%0d_gecerli", i - S + 1), {31'b0, gecerli_o}, 1);
        chk($sformatf("vec%0d_sonuc", i - S + 1), sonuc_o, tablo[i - S + 1].exp);
      end
    end
    step();
    chk("drain_gecerli", {31'b0, gecerli_o}, 0);
    chk("drain_mesgul", {31'b0, mesgul_o}, 0);

    // Stall mid-pipe for 4 cycles; result arrives exactly 4 cycles late, once.
    drive(1'b1, 2'd0, 32'h0F000000, 32'h0F000000);
    step();
    drive(1'b0, 2'd0, 32'h0F000000, 32'h0F000000);
    step();
    chk("stall_pre_gecerli", {31'b0, gecerli_o}, 0);
    durdur_i = 1'b1;
    drive(1'b1, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("stall%0d_gecerli", k), {31'b0, gecerli_o}, 0);
      chk($sformatf("stall%0d_mesgul", k), {31'b0, mesgul_o}, 1);
    end
    durdur_i = 1'b0;
    drive(1'b0, 2'd0, '0, '0);
    step();
    chk("stall_out_gecerli", {31'b0, gecerli_o}, 1);
    chk("stall_out_sonuc", sonuc_o, 32'h0);
    step();
    chk("stall_nodup_gecerli", {31'b0, gecerli_o}, 0);
    chk("stall_nodup_mesgul", {31'b0, mesgul_o}, 0);

    // Stall while the result sits in the output stage: it must hold.
    drive(1'b1, 2'd0, 32'd121, 32'hFFFFFFBA);
    step();
    drive(1'b0, 2'd0, '0, '0);
    step();
    step();
    chk("hold_gecerli", {31'b0, gecerli_o}, 1);
    chk("hold_sonuc", sonuc_o, 32'hFFFFDEEA);
    durdur_i = 1'b1;
    drive(1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("hold%0d_gecerli", k), {31'b0, gecerli_o}, 1);
      chk($sformatf("hold%0d_sonuc", k), sonuc_o, 32'hFFFFDEEA);
    end
    durdur_i = 1'b0;
    drive(1'b0, 2'd0, '0, '0);
    step();
    chk("hold_release_gecerli", {31'b0, gecerli_o}, 0);

    // Flush with stall and a valid input: everything dies, nothing is accepted.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, tablo[k].ctl, tablo[k].a, tablo[k].b);
      step();
    end
    chk("flush_pre_gecerli", {31'b0, gecerli_o}, 1);
    temizle_i = 1'b1;
    durdur_i  = 1'b1;
    drive(1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    chk("flush_gecerli", {31'b0, gecerli_o}, 0);
    chk("flush_mesgul", {31'b0, mesgul_o}, 0);
    temizle_i = 1'b0;
    durdur_i  = 1'b0;
    drive(1'b1, 2'd0, 32'd121, 32'hFFFFFFBA);
    step();
    drive(1'b0, 2'd0, '0, '0);
    chk("flush_next0_gecerli", {31'b0, gecerli_o}, 0);
    step();
    chk("flush_next1_gecerli", {31'b0, gecerli_o}, 0);
    step();
    chk("flush_next_gecerli", {31'b0, gecerli_o}, 1);
    chk("flush_next_sonuc", sonuc_o, 32'hFFFFDEEA);
    step();

    // Asynchronous reset between edges with ops in flight.
    drive(1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    step();
    step();
    #2;
    rst_i = 1'b0;
    #1;
    chk("areset_sonuc", sonuc_o, '0);
    chk("areset_gecerli", {31'b0, gecerli_o}, 0);
    chk("areset_mesgul", {31'b0, mesgul_o}, 0);
    drive(1'b0, 2'd0, '0, '0);
    step();
    rst_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("areset_after%0d_gecerli", k), {31'b0, gecerli_o}, 0);
      chk($sformatf("areset_after%0d_mesgul", k), {31'b0, mesgul_o}, 0);
    end

    // Random ops against a behavioural pipeline with stall/flush.
    for (int s = 0; s < S; s++) begin
      mv[s] = 1'b0;
      md[s] = '0;
    end
    for (int n = 0; n < 3000; n++) begin
      logic any;
      drive($urandom_range(3, 0) != 0, 2'($urandom_range(3, 0)), $urandom, $urandom);
      if (n % 7 == 0) deger1_i = ($urandom_range(1, 0) != 0) ? 32'hFFFFFFFF : 32'h80000000;
      durdur_i  = $urandom_range(4, 0) == 0;
      temizle_i = $urandom_range(15, 0) == 0;
      if (temizle_i) begin
        for (int s = 0; s < S; s++) mv[s] = 1'b0;
      end else if (!durdur_i) begin
        for (int s = S - 1; s > 0; s--) begin
          mv[s] = mv[s-1];
          md[s] = md[s-1];
        end
        mv[0] = gecerli_i;
        md[0] = ref_model(kontrol_i, deger1_i, deger2_i);
      end
      step();
      any = 1'b0;
      for (int s = 0; s < S; s++) any = any | mv[s];
      chk($sformatf("rnd%0d_gecerli", n), {31'b0, gecerli_o}, {31'b0, mv[S-1]});
      chk($sformatf("rnd%0d_mesgul", n), {31'b0, mesgul_o}, {31'b0, any});
      if (mv[S-1]) chk($sformatf("rnd%0d_sonuc", n), sonuc_o, md[S-1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
